// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor controller.
// The state encoding and nibble width are common to the controller and its datapath stage.
package nibble_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W         = 4;
    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// Stateless 4-bit ripple-carry adder stage, time-shared by the controller across nibble passes.
// Built from one full-adder cell per bit.
module add4_stage
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : gFullAdder
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: accepts an operand pair, runs one 4-bit pass per
// cycle through a shared add4_stage, then holds the result until the consumer takes it.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NIB   = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [NIB_W-1:0]   aNib_d;
    logic [NIB_W-1:0]   bNib_d;
    logic [NIB_W-1:0]   stageSum_d;
    logic               stageCout_d;
    logic               lastPass_d;

    assign aNib_d     = a_q[cnt_q*NIB_W +: NIB_W];
    assign bNib_d     = b_q[cnt_q*NIB_W +: NIB_W];
    assign lastPass_d = (cnt_q == CNT_W'(NIB - 1));

    add4_stage uStage (
        .a    (aNib_d),
        .b    (bNib_d),
        .cin  (carry_q),
        .s    (stageSum_d),
        .cout (stageCout_d)
    );

    // B is stored pre-inverted for subtraction so every pass is a plain add; the +1 comes in via carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt_q*NIB_W +: NIB_W] <= stageSum_d;
                    carry_q                     <= stageCout_d;
                    if (lastPass_d) begin
                        cnt_q   <= '0;
                        cout_q  <= stageCout_d;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (stageSum_d[NIB_W-1] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16, four passes per operation).
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int testsRun;
    int testsFailed;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents an operand pair once in_ready is seen, then counts edges from accept to out_valid.
    task automatic applyStimulus(input logic [15:0] aV, input logic [15:0] bV,
                                 input logic subV, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        a        = aV;
        b        = bV;
        op_sub   = subV;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic consumeResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        testsRun++; if (sum !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
        testsRun++; if (cout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        testsRun++; if (ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_vectors();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [15:0] es [6];
        logic        ec [6];
        logic        eo [6];
        int          lat;
        va = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
        vb = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h8000};
        vs = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
        es = '{16'h5555, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0000};
        ec = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
        eo = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(va[i], vb[i], vs[i], lat);
            testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL vec%0d_latency: got %0d expected 4", i, lat); end
            testsRun++; if (sum !== es[i]) begin testsFailed++; $display("[TB] FAIL vec%0d_sum: got %h expected %h", i, sum, es[i]); end
            testsRun++; if (cout !== ec[i]) begin testsFailed++; $display("[TB] FAIL vec%0d_cout: got %b expected %b", i, cout, ec[i]); end
            testsRun++; if (ovf !== eo[i]) begin testsFailed++; $display("[TB] FAIL vec%0d_ovf: got %b expected %b", i, ovf, eo[i]); end
            consumeResult();
            testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL vec%0d_idle_after: got %b expected 1", i, in_ready); end
        end
    endtask

    task automatic test_operand_change();
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hF0F0; b = 16'h0F0F; op_sub = 1'b1;
        @(posedge clk);
        #1;
        testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL run_in_ready: got %b expected 0", in_ready); end
        a = 16'hABCD; b = 16'h9876;
        repeat (3) @(posedge clk);
        #1;
        testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_out_valid: got %b expected 1", out_valid); end
        testsRun++; if (sum !== 16'h3333) begin testsFailed++; $display("[TB] FAIL hold_sum: got %h expected 3333", sum); end
        consumeResult();
    endtask

    task automatic test_backpressure();
        int lat;
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, lat);
        testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; op_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (sum !== 16'h1000 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold%0d: got sum=%h cout=%b ovf=%b ov=%b ir=%b expected sum=1000 cout=0 ovf=0 ov=1 ir=0",
                         i, sum, cout, ovf, out_valid, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        testsRun++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_exit_idle: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_accept: got ir=%b expected 0", in_ready); end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = n; break; end
        end
        testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL bp_new_latency: got %0d expected 4", lat); end
        testsRun++; if (sum !== 16'h0406) begin testsFailed++; $display("[TB] FAIL bp_new_sum: got %h expected 0406", sum); end
        consumeResult();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit sawValid;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
        testsRun++; if (sum !== 16'h0000) begin testsFailed++; $display("[TB] FAIL mid_sum: got %h expected 0000", sum); end
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        testsRun++; if (sawValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_no_result: got %b expected 0", sawValid); end
        applyStimulus(16'h0001, 16'h0001, 1'b0, lat);
        testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL post_latency: got %0d expected 4", lat); end
        testsRun++; if (sum !== 16'h0002) begin testsFailed++; $display("[TB] FAIL post_sum: got %h expected 0002", sum); end
        consumeResult();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op_sub      = 1'b0;
        a           = '0;
        b           = '0;
        test_reset();
        test_vectors();
        test_operand_change();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a multiple of 4.
REQ-002 Parameter: NIB, default WIDTH/4, number of 4-bit passes.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  controller can accept operands.
REQ-007 op_sub  input  1  0 = A+B, 1 = A-B; sampled on accept.
REQ-008 a  input  WIDTH  operand A; sampled on accept.
REQ-009 b  input  WIDTH  operand B; sampled on accept.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement overflow.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on an edge with in_valid=1 in IDLE. On accept the block SHALL:
  - latch a into the A register;
  - latch b (bitwise inverted when op_sub=1) into the B register;
  - set the carry register to op_sub;
  - clear the nibble counter and clear sum;
  - go to RUN.
REQ-018 RUN, each cycle: one 4-bit add SHALL be performed on nibble[cnt] of A, nibble[cnt] of B and the carry register.
  - The 4-bit result SHALL be written to sum[4*cnt+3:4*cnt].
  - The carry register SHALL be loaded with the 4-bit carry-out.
  - cnt SHALL increment.
REQ-019 On the RUN cycle with cnt=NIB-1:
  - cout SHALL be loaded with the final carry;
  - ovf SHALL be loaded with (A[MSB]==Bop[MSB]) and (sum[MSB]!=A[MSB]), where Bop is the possibly inverted B register;
  - the FSM SHALL go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly NIB edges after the accept edge (4 for the default).
REQ-021 In DONE, sum/cout/ovf SHALL be held stable until out_valid and out_ready are both 1 on an edge; the FSM SHALL then go to IDLE.
REQ-022 Back-pressure: out_ready=0 SHALL hold DONE indefinitely with no output change.
REQ-023 in_valid while not in IDLE SHALL be ignored; no operand is lost, because the source holds it until in_ready.
REQ-024 Minimum issue interval SHALL be NIB+2 cycles; there is no back-to-back accept in the cycle DONE exits.
REQ-025 Wrap-around: sum SHALL be modulo 2^WIDTH, and carry-out beyond the MSB SHALL appear only on cout.
REQ-026 a, b and op_sub changing after accept SHALL NOT affect the operation in flight.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE, cnt=0 and carry=0. Output values after that edge:
  - in_ready=1, out_valid=0;
  - sum=0, cout=0, ovf=0.
REQ-028 rst during RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-030 A shared package SHALL hold:
  - the state enumeration (IDLE, RUN, DONE);
  - the nibble width constant (4);
  - the default WIDTH.
REQ-031 The 4-bit datapath SHALL be one combinational sub-module, add4_stage.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Built as a ripple of full-adder bit cells.
  - Instantiated exactly once and time-shared across passes.
REQ-032 The controller SHALL contain all registers and the FSM; add4_stage SHALL be stateless.

Verification
REQ-033 Add 0x1234+0x4321 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 edges after accept.
REQ-034 Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 passes).
REQ-035 Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1; Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-036 Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
REQ-037 Back-pressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
  - sum/cout/ovf SHALL stay stable and in_ready SHALL stay 0.
  - After out_ready=1: IDLE for 1 cycle, then the new operands are accepted.
REQ-038 Reset mid-operation: assert rst on the 2nd RUN cycle.
  - Next edge: IDLE, in_ready=1, out_valid=0, sum=0.
  - A following 0x0001+0x0001 SHALL yield sum=0x0002.
